// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply datapath: mode encodings and
// the per-lane staircase delay used by the skew/deskew bank.
package matmul_pkg;

  typedef enum logic {
    MODE_SKEW   = 1'b0,
    MODE_DESKEW = 1'b1
  } mode_e;

  // Skew delays lane k by k steps; deskew mirrors the staircase.
  function automatic int unsigned lane_delay(input int unsigned k,
                                             input int unsigned step,
                                             input int unsigned lanes,
                                             input mode_e       mode);
    if (mode == MODE_DESKEW) begin
      return (lanes - 1 - k) * step;
    end
    return k * step;
  endfunction

endpackage

// File: rtl/lane_shift_reg.sv
// One lane of the delay bank: a DEPTH-stage shift register of data+valid with
// a selectable output tap. Invalid entries are stored as zero data.
module lane_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned TW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  input  logic [TW-1:0]    tap,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic             any_valid
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (en) begin
      valid_q   <= {valid_q[DEPTH-2:0], v};
      data_q[0] <= v ? d : '0;
      for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign qv        = valid_q[tap];
  assign q         = qv ? data_q[tap] : '0;
  assign any_valid = |valid_q;

endmodule

// File: rtl/skew_delay_bank.sv
// Multi-lane staircase delay: skews operand rows into the systolic array or
// deskews its result rows, with stall, busy and an idle-only mode switch.
module skew_delay_bank
  import matmul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   mode,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic                   din_valid,
  output logic [LANES*WIDTH-1:0] dout,
  output logic [LANES-1:0]       dout_valid,
  output logic                   busy,
  output logic                   mode_q
);

  localparam int unsigned MAXD  = (LANES - 1) * STEP;
  localparam int unsigned DEPTH = MAXD + 1;
  localparam int unsigned TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mode_e            mode_r;
  logic [LANES-1:0] any_v;

  // Mode only changes with nothing stored and nothing arriving, so taps never
  // move under a row in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= MODE_SKEW;
    end else if (en && !busy && !din_valid) begin
      mode_r <= mode_e'(mode);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [TW-1:0] tap;
    assign tap = TW'(lane_delay(k, STEP, LANES, mode_r));

    lane_shift_reg #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .d         (din[k*WIDTH +: WIDTH]),
      .v         (din_valid),
      .tap       (tap),
      .q         (dout[k*WIDTH +: WIDTH]),
      .qv        (dout_valid[k]),
      .any_valid (any_v[k])
    );
  end

  assign busy   = |any_v;
  assign mode_q = mode_r;

endmodule

// File: tb/tb_skew_delay_bank.sv
// Directed bench for skew_delay_bank: per-lane expected words are queued with
// their due cycle when a row is driven and retired when the DUT presents them.
module tb_skew_delay_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned STEP  = 1;
  localparam int unsigned MAXD  = (LANES - 1) * STEP;

  logic                   clk = 1'b0;
  logic                   reset, en, mode, din_valid;
  logic [LANES*WIDTH-1:0] din;
  logic [LANES*WIDTH-1:0] dout;
  logic [LANES-1:0]       dout_valid;
  logic                   busy, mode_q;

  skew_delay_bank #(.WIDTH(WIDTH), .LANES(LANES), .STEP(STEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .mode_q     (mode_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned      lane;
    int unsigned      due;
    logic [WIDTH-1:0] data;
  } sb_t;

  sb_t              sb[$];
  int unsigned      ecnt = 0;
  int unsigned      last_cap = 0;
  bit               have_row = 1'b0;
  logic             mode_m = 1'b0;
  logic             busy_m = 1'b0;
  logic             exp_v [LANES];
  logic [WIDTH-1:0] exp_d [LANES];
  int               errors = 0;
  int               checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned model_delay(input int unsigned k, input logic m);
    return m ? (LANES - 1 - k) * STEP : k * STEP;
  endfunction

  // Model the effect of one rising edge given the inputs that were applied.
  task automatic model_edge();
    bit busy_pre;
    if (reset) begin
      sb.delete();
      have_row = 1'b0;
      mode_m   = 1'b0;
      for (int k = 0; k < LANES; k++) begin exp_v[k] = 1'b0; exp_d[k] = '0; end
    end else if (en) begin
      busy_pre = busy_m;
      ecnt++;
      if (din_valid) begin
        for (int k = 0; k < LANES; k++) begin
          sb_t e;
          e.lane = k;
          e.due  = ecnt + model_delay(k, mode_m);
          e.data = din[k*WIDTH +: WIDTH];
          sb.push_back(e);
        end
        last_cap = ecnt;
        have_row = 1'b1;
      end else if (!busy_pre) begin
        mode_m = mode;
      end
      for (int k = 0; k < LANES; k++) begin
        exp_v[k] = 1'b0;
        exp_d[k] = '0;
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].lane == k && sb[i].due == ecnt) begin
            exp_v[k] = 1'b1;
            exp_d[k] = sb[i].data;
            sb.delete(i);
            break;
          end
        end
      end
    end
    busy_m = have_row && (ecnt <= last_cap + MAXD);
  endtask

  task automatic check_all();
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("c%0d_valid_l%0d", ecnt, k), 32'(dout_valid[k]), 32'(exp_v[k]));
      chk($sformatf("c%0d_data_l%0d", ecnt, k), 32'(dout[k*WIDTH +: WIDTH]), 32'(exp_d[k]));
    end
    chk($sformatf("c%0d_busy", ecnt), 32'(busy), 32'(busy_m));
    chk($sformatf("c%0d_mode_q", ecnt), 32'(mode_q), 32'(mode_m));
  endtask

  task automatic cyc(input logic r, input logic e, input logic m, input logic v,
                     input logic [LANES*WIDTH-1:0] d);
    reset = r; en = e; mode = m; din_valid = v; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [LANES*WIDTH-1:0] row(input logic [WIDTH-1:0] base,
                                                 input int unsigned stride);
    logic [LANES*WIDTH-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(base + k * stride);
    return r;
  endfunction

  task automatic idle(input int n, input logic m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, m, 1'b0, LANES*WIDTH'($urandom));
  endtask

  initial begin
    for (int k = 0; k < LANES; k++) begin exp_v[k] = 1'b0; exp_d[k] = '0; end
    reset = 1'b1; en = 1'b0; mode = 1'b0; din_valid = 1'b1; din = '0;
    #2;

    // reset held two edges with valid rows offered and en low then high
    cyc(1'b1, 1'b0, 1'b1, 1'b1, LANES*WIDTH'($urandom));
    cyc(1'b1, 1'b1, 1'b1, 1'b1, LANES*WIDTH'($urandom));
    idle(2, 1'b0);

    // skew, single row
    cyc(1'b0, 1'b1, 1'b0, 1'b1, row(8'h10, 1));
    idle(6, 1'b0);

    // streaming four rows back to back
    for (int r = 0; r < 4; r++) cyc(1'b0, 1'b1, 1'b0, 1'b1, row(WIDTH'(8'h40 + 4*r), 1));
    idle(7, 1'b0);

    // stall two cycles after the second edge of a row
    cyc(1'b0, 1'b1, 1'b0, 1'b1, row(8'h10, 1));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, row(8'hA0, 1));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, row(8'hB0, 1));
    idle(6, 1'b0);

    // mode raised while busy must not apply
    cyc(1'b0, 1'b1, 1'b1, 1'b1, row(8'h30, 1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(2, 1'b0);

    // idle edge switches to deskew, then a deskew row
    cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, row(8'h20, 1));
    idle(6, 1'b1);

    // reset mid-flight discards the row
    cyc(1'b0, 1'b1, 1'b1, 1'b1, row(8'h50, 1));
    cyc(1'b1, 1'b1, 1'b1, 1'b1, row(8'h60, 1));
    idle(6, 1'b0);

    // skew stream after reset, with an odd stride and a stall inside it
    cyc(1'b0, 1'b1, 1'b0, 1'b1, row(8'h81, 7));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, row(8'h11, 3));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, row(8'hC3, 5));
    idle(6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skew_delay_bank.md
Name: skew_delay_bank

Overview:
- Parametrised multi-lane delay line. Applies a per-lane staircase delay to one row of operand words so rows enter the systolic matrix-multiply array diagonally (skew mode).
- The same block removes that staircase from the array's result rows (deskew mode).
- Extends the single-bit registered delay to LANES lanes of WIDTH bits, with programmable step, per-lane valid tracking, stall, busy indication and a runtime mode.

Parameters:
- WIDTH, 8, data bits per lane
- LANES, 4, number of lanes (≥2)
- STEP, 1, extra cycles of delay between adjacent lanes (≥1)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state at the next rising edge
- en  input  1  advance enable; 0 freezes every register (stall)
- mode  input  1  0 = skew, 1 = deskew; sampled only when idle
- din  input  LANES*WIDTH  row input; lane k occupies bits [k*WIDTH +: WIDTH]
- din_valid  input  1  row valid, all lanes together
- dout  output  LANES*WIDTH  delayed lanes, same packing as din
- dout_valid  output  LANES  per-lane valid
- busy  output  1  any valid in flight or currently presented
- mode_q  output  1  mode currently applied

Behaviour:
- Delay per lane:
  - D_k = k*STEP in skew mode; (LANES-1-k)*STEP in deskew mode.
  - Latency of lane k = 1 + D_k enabled rising edges, counting the capture edge as the first.
  - MAXD = (LANES-1)*STEP.
- Capture and advance:
  - On a rising edge with en=1, din and din_valid enter stage 0 of every lane; all stages shift by one.
  - Lane k presents the stage at index D_k.
- Stall: with en=0, no stage, valid or mode_q changes. dout, dout_valid and busy hold. din is ignored, and a row offered while en=0 is not captured.
- Data zeroing: each lane's dout is zero whenever its dout_valid is 0. Storage also zeroes data on invalid entries so that no stale data is ever presented.
- Busy: combinational OR of all stored valid bits across all lanes and stages, including the presented stage.
- Mode update: mode_q updates from mode on an enabled edge only when busy=0 and din_valid=0 on that edge. Otherwise the mode input is ignored; a mode change while busy is never applied mid-flight.
- Streaming: back-to-back rows (din_valid=1 every enabled cycle) are supported with no bubbles. Throughput is one row per enabled cycle.
- Reset:
  - At the next rising edge, regardless of en: all stages, valids and data go to 0, mode_q=0, dout=0, dout_valid=0, busy=0.
  - Reset during flight discards all rows.
  - A din_valid on the reset edge is not captured.
- Boundary cases:
  - Lane with D_k=0 behaves as a single register.
  - Lane stage count = MAXD+1 for every lane, so taps can move with mode_q.
  - No overflow condition exists; data is never held back (no backpressure beyond en).

Decomposition:
- Shared package (matmul_pkg): mode encodings (MODE_SKEW=0, MODE_DESKEW=1) and a function computing lane delay from (k, STEP, LANES, mode).
- Sub-module lane_shift_reg:
  - parameters WIDTH, DEPTH(=MAXD+1)
  - ports clk, reset, en, d, v, tap select
  - outputs q, qv, any_valid
- Top: instantiates LANES copies, computes taps from mode_q, ORs any_valid into busy, owns the mode_q register.

Test Plan:
- Reset: hold reset 2 cycles with random din/din_valid=1 → dout=0, dout_valid=0000, busy=0, mode_q=0 throughout and after release.
- Skew, single row, WIDTH=8 LANES=4 STEP=1:
  - din lanes 0..3 = 0x10,0x11,0x12,0x13 with din_valid for one edge.
  - → lane0 shows 0x10 after edge 1, lane1 0x11 after edge 2, lane2 0x12 after edge 3, lane3 0x13 after edge 4, each for exactly one cycle.
  - busy is high from edge 1 through edge 4 and low after edge 5.
- Streaming: rows R0..R3 (lane k = 0x40+4*r+k) on 4 consecutive edges → each lane outputs its 4 words on consecutive cycles with no gaps. Lane3 finishes 3 cycles after lane0.
- Stall: single row as above, en=0 for 2 cycles after edge 2 → lane1 holds 0x11 valid for 3 cycles. Lane2/3 appear 2 cycles later than unstalled; no duplicates, no loss.
- Mode:
  - mode=1 asserted while busy → mode_q stays 0 and the row completes in skew order.
  - After idle, one enabled edge sets mode_q=1. A row 0x20..0x23 then yields lane3 after edge 1 and lane0 after edge 4.
- Reset mid-flight: row captured, reset on edge 2 → after that edge all dout_valid=0, dout=0, busy=0, and no remaining lanes ever emerge.
